soin_gshare_predictor: RTL
==========================

Name: soin_gshare_predictor

Overview:
- Parametrised gshare direction predictor; successor to the fixed 8-bit-GHR bimodal/global predictor in the soin fetch path.
- Sits beside fetch and produces a taken/not-taken prediction plus meta one cycle after a lookup.
- Keeps a speculative global history register (GHR) that is repaired on mispredict. Execute trains the counters through the meta round-trip.
- Clears its pattern history table (PHT) after reset with an internal init walker.

Parameters:
- IDX_W, 10, PHT index width; the table holds 2^IDX_W 2-bit counters.
- GHR_LEN, 10, global history length. Must satisfy GHR_LEN <= IDX_W.
- META_W, GHR_LEN+2+IDX_W, meta width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- bp_stall  in  1  freeze the prediction outputs and speculative GHR
- lookup_valid  in  1  lookup request this cycle
- lookup_PC  in  32  fetch PC of the request
- fetch_is_cond  in  1  the predicted instruction (cycle after lookup) is a conditional branch
- bp_ready  out  1  table initialised; lookups and updates are accepted
- pred_valid  out  1  p_dir/p_meta valid
- p_dir  out  1  predicted direction (counter MSB)
- p_meta  out  META_W  {ghr_snapshot[GHR_LEN], ctr[2], index[IDX_W]}
- upd_valid  in  1  execute resolves a conditional branch
- upd_taken  in  1  resolved direction
- upd_miss  in  1  resolved direction differs from the prediction
- upd_meta  in  META_W  meta carried from fetch
- ghr_spec  out  GHR_LEN  current speculative GHR (debug)

Behaviour:
- Reset values (async): bp_ready=0, pred_valid=0, p_dir=0, p_meta=0, ghr_spec=0; FSM enters INIT with init_ptr=0.
- FSM states:
  - INIT: each cycle write counter 2'b01 at init_ptr and increment init_ptr. At init_ptr=2^IDX_W-1 the FSM moves to READY. INIT lasts exactly 2^IDX_W cycles.
  - READY: bp_ready=1.
  - Reset asserted in any state returns the FSM to INIT and clears the GHR.
- While not ready: lookups and updates are ignored, pred_valid=0.
- Index = lookup_PC[IDX_W+1:2] XOR zero-extended ghr_spec.
- The PHT read is synchronous. pred_valid, p_dir and p_meta appear the cycle after lookup_valid (latency 1). p_meta captures the index, the counter read and ghr_spec as used for the index.
- Update (upd_valid in READY):
  - New counter = ctr from upd_meta, incremented on taken and decremented on not-taken, saturating at 2'b11 and 2'b00.
  - The write goes to upd_meta's index.
  - The write is single-cycle, with no internal read-modify-write.
- Read/write collision on the same index in the same cycle: the lookup returns the newly written counter (write-first bypass).
- Speculative GHR:
  - When pred_valid & fetch_is_cond & ~bp_stall: ghr_spec <= {ghr_spec[GHR_LEN-2:0], p_dir}.
  - On upd_valid & upd_miss: ghr_spec <= {upd_meta_ghr[GHR_LEN-2:0], upd_taken}.
  - A miss repair has priority over a same-cycle speculative shift.
- bp_stall:
  - Holds pred_valid, p_dir, p_meta and ghr_spec (except a miss repair, which still applies).
  - A lookup presented during a stall is dropped.
  - Updates proceed normally.
- No internal queue: updates are never back-pressured, and one update per cycle is accepted.

Test Plan:
- IDX_W=8, GHR_LEN=8: deassert reset -> bp_ready=0 for 256 cycles, 1 on cycle 257. Lookup PC 0x00000048 -> next cycle pred_valid=1, p_dir=0, p_meta ctr=01, index=0x12.
- Train: upd_valid, upd_meta={ghr 0, ctr 01, idx 0x12}, taken -> lookup PC 0x48 returns ctr=10, p_dir=1. Update ctr=11 taken keeps 11; update ctr=00 not-taken keeps 00.
- Speculative history: from ghr 0, two conditional predictions taken then not-taken -> ghr_spec=0x02. Then a miss with meta ghr 0x05, taken -> ghr_spec=0x0B.
- Simultaneous miss (meta ghr 0x01, not-taken) and fetch_is_cond with p_dir=1 -> ghr_spec=0x02 only.
- Bypass: an update writing 11 to index 0x30 in the same cycle as a lookup of index 0x30 -> p_meta ctr=11, p_dir=1.
- Reset pulse mid-training -> bp_ready drops immediately; after 256 cycles all lookups return ctr=01. An update during INIT does not alter any entry.

Source files
------------

// File: rtl/soin_gshare_predictor.sv
// gshare direction predictor: speculative GHR XOR PC indexes a 2-bit counter PHT.
// Counters are trained from the meta carried back by execute; an init walker clears the PHT after reset.
//
// state   | meaning
// S_INIT  | walker writes 2'b01 to every PHT entry; lookups and updates ignored
// S_READY | lookups, updates and GHR tracking active
module soin_gshare_predictor #(
    parameter int IDX_W   = 10,
    parameter int GHR_LEN = 10,
    localparam int META_W = GHR_LEN + 2 + IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bp_stall,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_PC,
    input  logic              fetch_is_cond,
    output logic              bp_ready,
    output logic              pred_valid,
    output logic              p_dir,
    output logic [META_W-1:0] p_meta,
    input  logic              upd_valid,
    input  logic              upd_taken,
    input  logic              upd_miss,
    input  logic [META_W-1:0] upd_meta,
    output logic [GHR_LEN-1:0] ghr_spec
);

    localparam int PHT_DEPTH = 1 << IDX_W;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_init_ptr;
    logic                 r_bp_ready;
    logic                 r_pred_valid;
    logic                 r_p_dir;
    logic [META_W-1:0]    r_p_meta;
    logic [GHR_LEN-1:0]   r_ghr_spec;
    logic [1:0]           r_pht [PHT_DEPTH];

    logic                 w_ready;
    logic                 w_upd_en;
    logic [IDX_W-1:0]     w_upd_idx;
    logic [1:0]           w_upd_ctr;
    logic [GHR_LEN-2:0]   w_upd_ghr_low;
    logic [1:0]           w_upd_new_ctr;
    logic                 w_pht_we;
    logic [IDX_W-1:0]     w_pht_waddr;
    logic [1:0]           w_pht_wdata;
    logic                 w_lkp_en;
    logic [IDX_W-1:0]     w_lkp_idx;
    logic [1:0]           w_lkp_ctr;
    logic                 w_unused;

    assign w_ready       = (r_state == S_READY);
    assign w_upd_en      = w_ready & upd_valid;
    assign w_upd_idx     = upd_meta[IDX_W-1:0];
    assign w_upd_ctr     = upd_meta[IDX_W+1:IDX_W];
    assign w_upd_ghr_low = upd_meta[META_W-2:IDX_W+2];

    always_comb begin
        w_upd_new_ctr = w_upd_ctr;
        if (upd_taken) begin
            if (w_upd_ctr != 2'b11) w_upd_new_ctr = w_upd_ctr + 2'b01;
        end else begin
            if (w_upd_ctr != 2'b00) w_upd_new_ctr = w_upd_ctr - 2'b01;
        end
    end

    // Single write port shared by the init walker and the training path
    assign w_pht_we    = (r_state == S_INIT) | w_upd_en;
    assign w_pht_waddr = (r_state == S_INIT) ? r_init_ptr : w_upd_idx;
    assign w_pht_wdata = (r_state == S_INIT) ? 2'b01 : w_upd_new_ctr;

    assign w_lkp_en  = w_ready & lookup_valid & ~bp_stall;
    assign w_lkp_idx = lookup_PC[IDX_W+1:2] ^ IDX_W'(r_ghr_spec);
    // Write-first: a same-cycle training write to the looked-up entry is forwarded
    assign w_lkp_ctr = (w_pht_we && (w_pht_waddr == w_lkp_idx)) ? w_pht_wdata
                                                                 : r_pht[w_lkp_idx];

    assign w_unused = ^{lookup_PC[31:IDX_W+2], lookup_PC[1:0], upd_meta[META_W-1]};

    always_ff @(posedge clk) begin
        if (w_pht_we) r_pht[w_pht_waddr] <= w_pht_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_INIT;
            r_init_ptr   <= '0;
            r_bp_ready   <= 1'b0;
            r_pred_valid <= 1'b0;
            r_p_dir      <= 1'b0;
            r_p_meta     <= '0;
            r_ghr_spec   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (r_init_ptr == '1) begin
                        r_state    <= S_READY;
                        r_bp_ready <= 1'b1;
                    end
                end
                S_READY: r_bp_ready <= 1'b1;
                default: r_state <= S_INIT;
            endcase

            if (!bp_stall) begin
                r_pred_valid <= w_lkp_en;
                if (w_lkp_en) begin
                    r_p_dir  <= w_lkp_ctr[1];
                    r_p_meta <= {r_ghr_spec, w_lkp_ctr, w_lkp_idx};
                end
            end

            if (w_upd_en && upd_miss)
                r_ghr_spec <= {w_upd_ghr_low, upd_taken};
            else if (r_pred_valid && fetch_is_cond && !bp_stall)
                r_ghr_spec <= {r_ghr_spec[GHR_LEN-2:0], r_p_dir};
        end
    end

    assign bp_ready   = r_bp_ready;
    assign pred_valid = r_pred_valid;
    assign p_dir      = r_p_dir;
    assign p_meta     = r_p_meta;
    assign ghr_spec   = r_ghr_spec;

endmodule
